// File: rtl/distram14_pkg.sv
// distram14_pkg: shared types for the 14-bit distributed-RAM tap reader.
//   DAT_W       - sample width
//   sample_t    - one 14-bit sample
//   tap_state_e - tap FSM states (FILL, RUN, CHANGE)
package distram14_pkg;

    localparam int DAT_W = 14;

    typedef logic [DAT_W-1:0] sample_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        CHANGE = 2'd2
    } tap_state_e;

endpackage

// File: rtl/distram14_ram.sv
// distram14_ram: DEPTH x 14 simple dual-port distributed RAM.
// Synchronous write, asynchronous (combinational) read, no reset.
// Ports:
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module distram14_ram
    import distram14_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  sample_t               wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output sample_t               rdata_o
);

    sample_t mem [2**DEPTH_LOG2];

    // NOTE: the storage array has no reset so it maps onto LUT RAM; stale
    //       contents are hidden by the fill tracking in the tap reader.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/distram14_tap_reader.sv
// distram14_tap_reader: programmable-delay read tap on a circular history
// buffer. Each clock the input sample is written at the write pointer; the
// tap returns the sample written DELAY+1 clocks earlier.
// Ports:
//   clk_i        - sample clock
//   rst_n_i      - asynchronous active-low reset
//   dat_i        - input sample, written every clock
//   delay_i      - requested tap delay D
//   delay_wr_i   - load strobe for delay_i
//   delay_busy_o - high during the one-cycle change guard; loads ignored
//   delay_cur_o  - active tap delay
//   delay_err_o  - one-cycle pulse when a load was clamped to DEPTH-2
//   dat_o        - delayed sample (registered)
//   valid_o      - dat_o is a genuinely written sample at the active delay
// Build option:
//   DISTRAM14_TAP_ZERO_FILL_EN - force dat_o to zero whenever valid_o is low.
module distram14_tap_reader
    import distram14_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int INIT_DELAY = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  sample_t               dat_i,
    input  logic [DEPTH_LOG2-1:0] delay_i,
    input  logic                  delay_wr_i,
    output logic                  delay_busy_o,
    output logic [DEPTH_LOG2-1:0] delay_cur_o,
    output logic                  delay_err_o,
    output sample_t               dat_o,
    output logic                  valid_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] MAX_DELAY = DEPTH_LOG2'(DEPTH - 2);
    localparam logic [DEPTH_LOG2-1:0] FILL_MAX  = DEPTH_LOG2'(DEPTH - 1);

    logic [DEPTH_LOG2-1:0] wptr_q,  wptr_d;
    logic [DEPTH_LOG2-1:0] fill_q,  fill_d;
    logic [DEPTH_LOG2-1:0] delay_q, delay_d;
    tap_state_e            state_q, state_d;
    sample_t               dat_q,   dat_d;
    logic                  valid_q, valid_d;
    logic                  err_q,   err_d;

    logic [DEPTH_LOG2-1:0] raddr;
    sample_t               rd_data;
    logic                  primed;
    logic                  load_acc;

    // Pre-edge write pointer minus (D+1); D+1 <= DEPTH-1 keeps raddr != wptr.
    assign raddr = wptr_q - delay_q - DEPTH_LOG2'(1);

    // fill >= D+1; fill saturates at DEPTH-1 and D <= DEPTH-2, so no overflow.
    assign primed   = (fill_q > delay_q);
    assign load_acc = delay_wr_i && (state_q != CHANGE);

    distram14_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (1'b1),
        .waddr_i (wptr_q),
        .wdata_i (dat_i),
        .raddr_i (raddr),
        .rdata_o (rd_data)
    );

    // NOTE: every signal gets a default before any branch, so no path can
    //       leave one unassigned and infer a latch.
    always_comb begin
        wptr_d  = wptr_q + DEPTH_LOG2'(1);
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + DEPTH_LOG2'(1);
        delay_d = delay_q;
        err_d   = 1'b0;
        state_d = state_q;

        unique case (state_q)
            FILL:    state_d = primed ? RUN : FILL;
            RUN:     state_d = RUN;
            CHANGE:  state_d = primed ? RUN : FILL;
            default: state_d = FILL;
        endcase

        // An accepted load overrides the normal transition; the read at this
        // edge still uses the old delay, the new one governs the next edge.
        if (load_acc) begin
            state_d = CHANGE;
            err_d   = (delay_i > MAX_DELAY);
            delay_d = (delay_i > MAX_DELAY) ? MAX_DELAY : delay_i;
        end

        valid_d = (state_d == RUN);

`ifdef DISTRAM14_TAP_ZERO_FILL_EN
        dat_d = valid_d ? rd_data : '0;
`else
        dat_d = rd_data;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    //       samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            fill_q  <= '0;
            delay_q <= DEPTH_LOG2'(INIT_DELAY);
            state_q <= FILL;
            dat_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            delay_q <= delay_d;
            state_q <= state_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign delay_busy_o = (state_q == CHANGE);
    assign delay_cur_o  = delay_q;
    assign delay_err_o  = err_q;
    assign dat_o        = dat_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_distram14_tap_reader.sv
// tb_distram14_tap_reader: directed bench for distram14_tap_reader.
// A history-array model predicts every output from the delay-line rules
// (output = sample captured D+1 edges earlier, valid once D+1 samples exist,
// one blanked cycle after each accepted load); it is compared on every
// falling edge. Literal checks pin reset, latency, clamp and busy behaviour.
module tb_distram14_tap_reader;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [13:0] dat_i = '0;
    logic [4:0]  delay_i = '0;
    logic        delay_wr_i = 1'b0;
    logic        delay_busy_o;
    logic [4:0]  delay_cur_o;
    logic        delay_err_o;
    logic [13:0] dat_o;
    logic        valid_o;

    int checks = 0;
    int failures = 0;

    bit ramp_on = 1'b0;
    int ramp = 0;

    distram14_tap_reader #(
        .DEPTH_LOG2 (5),
        .INIT_DELAY (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .dat_i        (dat_i),
        .delay_i      (delay_i),
        .delay_wr_i   (delay_wr_i),
        .delay_busy_o (delay_busy_o),
        .delay_cur_o  (delay_cur_o),
        .delay_err_o  (delay_err_o),
        .dat_o        (dat_o),
        .valid_o      (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_n = 0;          // samples written since reset
    int          m_d = 4;          // active delay
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;
    logic [13:0] m_dat = '0;
    logic [13:0] hist [0:8191];

    always @(posedge clk_i or negedge rst_n_i) begin
        bit accept;
        if (!rst_n_i) begin
            m_n = 0; m_d = 4; m_busy = 0; m_valid = 0; m_err = 0; m_dat = '0;
        end else begin
            accept  = delay_wr_i && !m_busy;
            m_valid = !accept && (m_n >= m_d + 1);
            if (m_valid) m_dat = hist[(m_n - m_d - 1) % 8192];
            m_err   = accept && (delay_i > 5'd30);
            if (accept) m_d = (delay_i > 5'd30) ? 30 : int'(delay_i);
            m_busy  = accept;
            hist[m_n % 8192] = dat_i;
            m_n++;
        end
    end

    always @(negedge clk_i) begin
        check("valid", 32'(valid_o), 32'(m_valid));
        check("busy", 32'(delay_busy_o), 32'(m_busy));
        check("err", 32'(delay_err_o), 32'(m_err));
        check("delay_cur", 32'(delay_cur_o), 32'(m_d));
        if (m_valid) check("dat", 32'(dat_o), 32'(m_dat));
`ifdef DISTRAM14_TAP_ZERO_FILL_EN
        if (!m_valid) check("dat_zero", 32'(dat_o), 32'd0);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #2;
        if (ramp_on) begin
            dat_i = 14'(ramp);
            ramp++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Value expected on dat_o now, given delay d (captured sample = ramp-2).
    function automatic logic [31:0] ramp_exp(input int d);
        return 32'(14'(ramp - 2 - (d + 1)));
    endfunction

    initial begin
        #1 rst_n_i = 1'b0;
        #11;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_dat", 32'(dat_o), 32'd0);
        check("rst_busy", 32'(delay_busy_o), 32'd0);
        check("rst_err", 32'(delay_err_o), 32'd0);
        check("rst_cur", 32'(delay_cur_o), 32'd4);

        // Reset default: single 1234 sample, latency 5 clocks.
        #10;
        rst_n_i = 1'b1;
        dat_i   = 14'h1234;
        tick();                 // edge 1 captures 1234
        dat_i = '0;
        ticks(4);               // edges 2..5
        check("dflt_not_yet", 32'(valid_o), 32'd0);
        tick();                 // edge 6
        check("dflt_valid", 32'(valid_o), 32'd1);
        check("dflt_dat", 32'(dat_o), 32'h1234);
        tick();
        check("dflt_single", 32'(dat_o), 32'd0);

        // Ramp, then load D=10.
        ramp = 32'h100;
        ramp_on = 1'b1;
        ticks(40);
        delay_wr_i = 1'b1; delay_i = 5'd10;
        tick();
        delay_wr_i = 1'b0;
        check("d10_busy", 32'(delay_busy_o), 32'd1);
        check("d10_blank", 32'(valid_o), 32'd0);
        check("d10_cur", 32'(delay_cur_o), 32'd10);
        tick();
        check("d10_unbusy", 32'(delay_busy_o), 32'd0);
        check("d10_valid", 32'(valid_o), 32'd1);
        check("d10_dat", 32'(dat_o), ramp_exp(10));
        ticks(20);

        // Max with clamp.
        delay_wr_i = 1'b1; delay_i = 5'd31;
        tick();
        delay_wr_i = 1'b0;
        check("clamp_err", 32'(delay_err_o), 32'd1);
        check("clamp_cur", 32'(delay_cur_o), 32'd30);
        tick();
        check("clamp_err_gone", 32'(delay_err_o), 32'd0);
        ticks(35);
        check("d30_valid", 32'(valid_o), 32'd1);
        check("d30_dat", 32'(dat_o), ramp_exp(30));

        // Minimum delay.
        delay_wr_i = 1'b1; delay_i = 5'd0;
        tick();
        delay_wr_i = 1'b0;
        tick();
        check("d0_valid", 32'(valid_o), 32'd1);
        check("d0_dat", 32'(dat_o), ramp_exp(0));
        ticks(5);

        // Busy drop: second consecutive strobe is ignored.
        delay_wr_i = 1'b1; delay_i = 5'd7;
        tick();
        delay_i = 5'd3;
        tick();
        delay_wr_i = 1'b0;
        check("drop_cur", 32'(delay_cur_o), 32'd7);
        tick();
        check("drop_cur2", 32'(delay_cur_o), 32'd7);
        check("drop_busy", 32'(delay_busy_o), 32'd0);
        ticks(10);

        // Mid-stream asynchronous reset with D=10.
        delay_wr_i = 1'b1; delay_i = 5'd10;
        tick();
        delay_wr_i = 1'b0;
        ticks(15);
        #1 rst_n_i = 1'b0;
        #1;
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_dat", 32'(dat_o), 32'd0);
        check("mrst_busy", 32'(delay_busy_o), 32'd0);
        check("mrst_cur", 32'(delay_cur_o), 32'd4);
        tick();
        rst_n_i = 1'b1;

        // Early load: D=20 at fill=6.
        ticks(6);               // edges 1..6
        delay_wr_i = 1'b1; delay_i = 5'd20;
        tick();                 // edge 7
        delay_wr_i = 1'b0;
        check("early_busy", 32'(delay_busy_o), 32'd1);
        ticks(13);              // edges 8..20
        tick();                 // edge 21
        check("early_fill", 32'(valid_o), 32'd0);
        tick();                 // edge 22
        check("early_valid", 32'(valid_o), 32'd1);
        check("early_dat", 32'(dat_o), ramp_exp(20));
        ticks(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/distram14_tap_reader.md
Name: distram14_tap_reader

Overview:
- Programmable-delay read tap on a 14-bit distributed-RAM circular history buffer.
- Every clock, the incoming sample is written at the write pointer.
- A runtime-loadable tap reads the sample written DELAY+1 clocks earlier.
- Sits between per-channel sample streams and trigger/beamform logic, so channels can be realigned at run time without a fixed-delay rebuild.
- The tap has a load handshake, fill tracking after reset, and a one-cycle blanking guard on each delay change.

Parameters:
- DEPTH_LOG2, 5, log2 of buffer depth (DEPTH = 32 entries of 14 bits, distributed RAM).
- INIT_DELAY, 4, tap delay value after reset (4 = 5 clocks of latency); must be ≤ DEPTH-2.

Ports:
- clk_i  in  1  sample clock; the block's only clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- dat_i  in  14  input sample, written every clock.
- delay_i  in  DEPTH_LOG2  requested tap delay D.
- delay_wr_i  in  1  load strobe for delay_i.
- delay_busy_o  out  1  high while a delay change is in progress; loads are ignored while high.
- delay_cur_o  out  DEPTH_LOG2  active tap delay.
- delay_err_o  out  1  one-cycle pulse when a load requested D > DEPTH-2 (clamped).
- dat_o  out  14  delayed sample, registered.
- valid_o  out  1  dat_o holds a genuinely written sample at the active delay.

Behaviour:
- Interface: single clock clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: wptr=0, fill=0, state=FILL, delay_cur_o=INIT_DELAY, dat_o=0, valid_o=0, delay_busy_o=0, delay_err_o=0.
- RAM contents are not reset; they are masked by fill tracking.
- Write path:
  - Every posedge: mem[wptr] <= dat_i, then wptr <= wptr+1 (mod DEPTH).
  - No stall input.
- Read path:
  - raddr = wptr - (D+1) mod DEPTH, using pre-edge wptr; asynchronous distram read.
  - dat_o <= mem[raddr] at the same edge.
  - A sample presented before edge k appears on dat_o after edge k+D+1.
  - D+1 ≤ DEPTH-1, so raddr never equals wptr; no read-during-write hazard.
- fill counter:
  - Increments each clock, saturating at DEPTH-1.
  - Tap is "primed" when fill ≥ D+1.
- State machine:
  - FILL: valid_o <= 0. Go to RUN when primed (evaluated against the registered D).
  - RUN: valid_o <= 1.
  - CHANGE: entered for exactly one clock after an accepted load.
    - valid_o <= 0 and delay_busy_o=1.
    - Exits to RUN if primed with the new D, else to FILL.
- Load handshake:
  - A load is accepted when delay_wr_i=1 and state≠CHANGE.
  - The new D is registered at the accept edge and governs raddr from the next edge onward.
  - delay_busy_o is high during CHANGE.
  - A strobe during CHANGE is dropped silently; the requester must resample busy.
- Clamping: delay_i > DEPTH-2 is clamped to DEPTH-2, and delay_err_o pulses for 1 clock coincident with CHANGE.
- Same value reloaded: a load with delay_i equal to the current D still enters CHANGE (uniform behaviour).
- Delay decrease below fill: no effect on priming; only fill vs. new D matters.
- Reset mid-operation: everything returns to reset values immediately; the first valid output follows INIT_DELAY+1 written samples after release.
- Continuous operation: wptr and fill are unaffected by loads; the write side never pauses.

Optional Feature:
- Macro: DISTRAM14_TAP_ZERO_FILL_EN.
- Defined: dat_o is forced to 14'h0000 on any edge where valid_o is registered low (FILL, CHANGE).
- Undefined: dat_o always carries raw mem[raddr]. In FILL this may be stale or X in simulation; consumers must qualify with valid_o.
- No other logic differs between the two builds.

Decomposition:
- Package distram14_pkg holds:
  - localparam DAT_W=14;
  - the sample typedef (logic [13:0]);
  - the tap state enum {FILL, RUN, CHANGE}.
- One sub-module, distram14_ram:
  - DEPTH x 14 simple dual-port distributed RAM;
  - synchronous write, asynchronous read;
  - no reset.
- Pointer, fill, handshake and FSM logic stay in the top.

Test Plan:
- Reset default: release reset, drive dat_i=14'h1234 for 1 clock, then 0 → valid_o rises after 5 edges; 14'h1234 appears exactly 5 clocks after its capture edge, single cycle.
- Ramp: drive dat_i ramp, load D=10 → after one-cycle CHANGE (valid_o=0, busy=1), dat_o = ramp value from 11 clocks earlier, with no further gaps.
- Max and clamp: load D=31 → delay_err_o pulses once, delay_cur_o=30, latency 31 clocks on the ramp; load D=0 → latency 1 clock.
- Busy drop: strobe delay_wr_i on two consecutive clocks (D=7, then D=3) → second strobe dropped, delay_cur_o=7.
- Early load: load D=20 at fill=6 after reset → FILL persists until fill=21, then valid_o=1 with correct data.
- Mid-stream reset: assert rst_n_i asynchronously (between edges) while D=10 → all outputs 0 immediately, delay_cur_o=4.
- Zero-fill build: with DISTRAM14_TAP_ZERO_FILL_EN, check dat_o=0 whenever valid_o=0; without it, the bench qualifies on valid_o only.
